// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MIPS32 memory-access stage fused with the MEM/WB pipeline register.
// Performs byte/halfword/word loads and stores against an internal little-endian,
// word-organised RAM, flags and suppresses misaligned accesses, and registers the
// write-back bundle for the next stage.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   WB                {RegWrite, MemToReg} from EX/MEM
//   M                 {Branch (unused), MemRead, MemWrite} from EX/MEM
//   mem_size          00 byte, 01 halfword, 10/11 word
//   mem_unsigned      1 = zero-extend sub-word loads, 0 = sign-extend
//   alu_result        byte address / ALU result
//   store_data        store operand (rt)
//   AWriteReg_in      destination register
//   WB_out            registered WB control (RegWrite squashed on misalign)
//   mem_data_out      registered load data (0 when no valid load)
//   alu_result_out    registered copy of alu_result
//   AWriteReg_out     registered destination register
//   misalign          registered misaligned-access flag
module mem_wb_stage #(
   parameter int unsigned SIZE      = 32,
   parameter int unsigned ADDR_SIZE = 5,
   parameter int unsigned S_WB      = 2,
   parameter int unsigned S_M       = 3,
   parameter int unsigned MEM_AW    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [S_WB-1:0]      WB,
   input  logic [S_M-1:0]       M,
   input  logic [1:0]           mem_size,
   input  logic                 mem_unsigned,
   input  logic [SIZE-1:0]      alu_result,
   input  logic [SIZE-1:0]      store_data,
   input  logic [ADDR_SIZE-1:0] AWriteReg_in,
   output logic [S_WB-1:0]      WB_out,
   output logic [SIZE-1:0]      mem_data_out,
   output logic [SIZE-1:0]      alu_result_out,
   output logic [ADDR_SIZE-1:0] AWriteReg_out,
   output logic                 misalign
);

   localparam int unsigned DEPTH = 2 ** MEM_AW;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   // Word-organised data RAM; contents intentionally not reset.
   logic [SIZE-1:0] r_mem [DEPTH];

   logic [MEM_AW-1:0] w_word_idx;
   logic [1:0]        w_lane;
   logic              w_mem_read;
   logic              w_mem_write;
   logic              w_misalign;
   logic [SIZE-1:0]   w_rd_word;
   logic [7:0]        w_rd_byte;
   logic [15:0]       w_rd_half;
   logic [SIZE-1:0]   w_load_data;
   logic [SIZE-1:0]   w_wr_data;
   logic [SIZE-1:0]   w_wr_mask;
   logic [SIZE-1:0]   w_wr_word;
   logic              w_we;
   logic [S_WB-1:0]   w_wb_nxt;
   logic [SIZE-1:0]   w_mem_data_nxt;
   logic              w_unused;

   // Address decode: high address bits beyond the RAM are ignored (wrap).
   assign w_word_idx  = alu_result[MEM_AW+1:2];
   assign w_lane      = alu_result[1:0];
   assign w_mem_read  = M[1];
   assign w_mem_write = M[0];

   assign w_unused = ^{alu_result[SIZE-1:MEM_AW+2], M[S_M-1:2]};

   // Alignment check, only meaningful for memory slots.
   always_comb begin
      w_misalign = 1'b0;
      if (w_mem_read || w_mem_write) begin
         case (mem_size)
            SZ_BYTE: w_misalign = 1'b0;
            SZ_HALF: w_misalign = w_lane[0];
            default: w_misalign = (w_lane != 2'b00);
         endcase
      end
   end

   // Combinational read of the addressed word (pre-write contents).
   assign w_rd_word = r_mem[w_word_idx];
   assign w_rd_byte = w_rd_word[{w_lane, 3'b000} +: 8];
   assign w_rd_half = w_lane[1] ? w_rd_word[31:16] : w_rd_word[15:0];

   // Lane extraction and sign/zero extension.
   always_comb begin
      w_load_data = '0;
      case (mem_size)
         SZ_BYTE: w_load_data = mem_unsigned ? {{(SIZE-8){1'b0}}, w_rd_byte}
                                             : {{(SIZE-8){w_rd_byte[7]}}, w_rd_byte};
         SZ_HALF: w_load_data = mem_unsigned ? {{(SIZE-16){1'b0}}, w_rd_half}
                                             : {{(SIZE-16){w_rd_half[15]}}, w_rd_half};
         default: w_load_data = w_rd_word;
      endcase
   end

   // Store lane mask and replicated write data; merged into the old word.
   always_comb begin
      w_wr_data = store_data;
      w_wr_mask = '1;
      case (mem_size)
         SZ_BYTE: begin
            w_wr_data = {4{store_data[7:0]}};
            w_wr_mask = SIZE'(32'h0000_00FF) << {w_lane, 3'b000};
         end
         SZ_HALF: begin
            w_wr_data = {2{store_data[15:0]}};
            w_wr_mask = w_lane[1] ? SIZE'(32'hFFFF_0000) : SIZE'(32'h0000_FFFF);
         end
         default: begin
            w_wr_data = store_data;
            w_wr_mask = '1;
         end
      endcase
   end

   assign w_wr_word = (w_rd_word & ~w_wr_mask) | (w_wr_data & w_wr_mask);
   assign w_we      = w_mem_write && !w_misalign && !rst;

   // RAM write port; stores during reset are dropped.
   always_ff @(posedge clk) begin
      if (w_we) begin
         r_mem[w_word_idx] <= w_wr_word;
      end
   end

   // Next-state values for the MEM/WB register.
   always_comb begin
      w_wb_nxt       = WB;
      w_mem_data_nxt = '0;
      if (w_misalign) begin
         w_wb_nxt = {1'b0, WB[0]};
      end else if (w_mem_read) begin
         w_mem_data_nxt = w_load_data;
      end
   end

   // MEM/WB pipeline register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         WB_out         <= '0;
         mem_data_out   <= '0;
         alu_result_out <= '0;
         AWriteReg_out  <= '0;
         misalign       <= 1'b0;
      end else begin
         WB_out         <= w_wb_nxt;
         mem_data_out   <= w_mem_data_nxt;
         alu_result_out <= alu_result;
         AWriteReg_out  <= AWriteReg_in;
         misalign       <= w_misalign;
      end
   end

endmodule
